biquad_scheduler: RTL and testbench

BIQUAD_SCHEDULER -- requirements
Module: biquad_scheduler

---
 rtl/biquad_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_biquad_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_scheduler.sv
// biquad_scheduler -- time-multiplexes one shared double_biquad engine over
// N_BANDS bands.  Each accepted sample pair runs three passes per band, in
// the order MOD(b), ENV(b), CAR(b) for b = 0..N_BANDS-1.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   valid_in, *_sample_in     new modulator/carrier sample pair (strobe)
//   ready_out                 idle, a valid_in this cycle is accepted
//   eng_valid_out, eng_*_out  operand strobe + coefficient row + operands
//   eng_valid_in, eng_*_in    engine result strobe + i[n], y[n]
//   band_valid_out, band_out, envelope_out, carrier_out   per-band results
//   frame_done_out            strobe with the last band result
//   overrun_count_out         (only with SCHED_OVERRUN_CNT_EN) saturating
//                             count of valid_in pulses dropped while busy
//
// Optional feature macro: SCHED_OVERRUN_CNT_EN.

// Per-band filter state: two-deep i/y history for each of the three passes.
module biquad_band_hist (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 wr_en,
  input  logic [1:0]           wr_pass,
  input  logic [31:0]          i_new,
  input  logic [31:0]          y_new,
  output logic [2:0][31:0]     i0,
  output logic [2:0][31:0]     i1,
  output logic [2:0][31:0]     y0,
  output logic [2:0][31:0]     y1
);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i0 <= '0;
      i1 <= '0;
      y0 <= '0;
      y1 <= '0;
    end else if (wr_en) begin
      i1[wr_pass] <= i0[wr_pass];
      i0[wr_pass] <= i_new;
      y1[wr_pass] <= y0[wr_pass];
      y0[wr_pass] <= y_new;
    end
  end
endmodule

module biquad_scheduler #(
  parameter int N_BANDS = 8,
  parameter int ROW_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [31:0]       modulator_sample_in,
  input  logic [31:0]       carrier_sample_in,
  output logic              ready_out,
  output logic              eng_valid_out,
  output logic [ROW_W-1:0]  eng_row_out,
  output logic [31:0]       eng_x_n_out,
  output logic [31:0]       eng_x_n1_out,
  output logic [31:0]       eng_x_n2_out,
  output logic [31:0]       eng_i_n1_out,
  output logic [31:0]       eng_i_n2_out,
  output logic [31:0]       eng_y_n1_out,
  output logic [31:0]       eng_y_n2_out,
  input  logic              eng_valid_in,
  input  logic [31:0]       eng_i_n_in,
  input  logic [31:0]       eng_y_n_in,
  output logic [ROW_W-1:0]  band_out,
  output logic [31:0]       envelope_out,
  output logic [31:0]       carrier_out,
  output logic              band_valid_out,
`ifdef SCHED_OVERRUN_CNT_EN
  output logic [15:0]       overrun_count_out,
`endif
  output logic              frame_done_out
);
  localparam int BI_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam logic [1:0] P_MOD = 2'd0;
  localparam logic [1:0] P_ENV = 2'd1;
  localparam logic [1:0] P_CAR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [31:0]      xn;
    logic [31:0]      xn1;
    logic [31:0]      xn2;
    logic [31:0]      in1;
    logic [31:0]      in2;
    logic [31:0]      yn1;
    logic [31:0]      yn2;
  } eng_op_t;

  state_t           state, state_nxt;
  logic [BI_W-1:0]  band_idx;
  logic [1:0]       pass;
  logic [31:0]      mod_x0, mod_x1, mod_x2;
  logic [31:0]      car_x0, car_x1, car_x2;
  logic [31:0]      env_y2_pre;
  eng_op_t          op_cur, op_hold, op_out;
  logic             accept, capture, last_band;

  logic [N_BANDS-1:0][2:0][31:0] h_i0, h_i1, h_y0, h_y1;

  // Magnitude with the single unrepresentable case clamped.
  function automatic logic [31:0] sat_abs(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7fff_ffff;
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // ready_out drops during the frame_done cycle so a new frame never
  // overlaps the final result strobe.
  assign ready_out = (state == S_IDLE) && !rst_in && !frame_done_out;
  assign accept    = ready_out && valid_in;
  assign capture   = (state == S_WAIT) && eng_valid_in;
  assign last_band = (band_idx == BI_W'(N_BANDS - 1));

  for (genvar b = 0; b < N_BANDS; b++) begin : g_band
    biquad_band_hist u_hist (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .wr_en   (capture && (band_idx == BI_W'(b))),
      .wr_pass (pass),
      .i_new   (eng_i_n_in),
      .y_new   (eng_y_n_in),
      .i0      (h_i0[b]),
      .i1      (h_i1[b]),
      .y0      (h_y0[b]),
      .y1      (h_y1[b])
    );
  end

  // FSM
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (capture)
                 state_nxt = (pass == P_CAR && last_band) ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands for the current (band, pass).  Histories and counters have
  // already been updated by the capture edge, so this is valid in ISSUE.
  always_comb begin
    op_cur.row = ROW_W'(band_idx);
    op_cur.xn  = mod_x0;
    op_cur.xn1 = mod_x1;
    op_cur.xn2 = mod_x2;
    op_cur.in1 = h_i0[band_idx][pass];
    op_cur.in2 = h_i1[band_idx][pass];
    op_cur.yn1 = h_y0[band_idx][pass];
    op_cur.yn2 = h_y1[band_idx][pass];
    case (pass)
      P_ENV: begin
        // The modulator y history has already shifted: y0 = this frame,
        // y1 = pre-frame y[n-1]; pre-frame y[n-2] was saved aside at capture.
        op_cur.row = ROW_W'(N_BANDS);
        op_cur.xn  = sat_abs(h_y0[band_idx][P_MOD]);
        op_cur.xn1 = sat_abs(h_y1[band_idx][P_MOD]);
        op_cur.xn2 = sat_abs(env_y2_pre);
      end
      P_CAR: begin
        op_cur.xn  = car_x0;
        op_cur.xn1 = car_x1;
        op_cur.xn2 = car_x2;
      end
      default: ;
    endcase
  end

  // Operands are live in ISSUE and frozen afterwards until the next ISSUE.
  assign op_out        = (state == S_ISSUE) ? op_cur : op_hold;
  assign eng_valid_out = (state == S_ISSUE);
  assign eng_row_out   = op_out.row;
  assign eng_x_n_out   = op_out.xn;
  assign eng_x_n1_out  = op_out.xn1;
  assign eng_x_n2_out  = op_out.xn2;
  assign eng_i_n1_out  = op_out.in1;
  assign eng_i_n2_out  = op_out.in2;
  assign eng_y_n1_out  = op_out.yn1;
  assign eng_y_n2_out  = op_out.yn2;

  // Datapath
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      band_idx       <= '0;
      pass           <= P_MOD;
      mod_x0         <= '0;
      mod_x1         <= '0;
      mod_x2         <= '0;
      car_x0         <= '0;
      car_x1         <= '0;
      car_x2         <= '0;
      env_y2_pre     <= '0;
      op_hold        <= '0;
      band_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      band_out       <= '0;
      envelope_out   <= '0;
      carrier_out    <= '0;
    end else begin
      band_valid_out <= 1'b0;
      frame_done_out <= 1'b0;
      if (accept) begin
        mod_x0   <= modulator_sample_in;
        car_x0   <= carrier_sample_in;
        band_idx <= '0;
        pass     <= P_MOD;
      end
      if (state == S_ISSUE) op_hold <= op_cur;
      if (capture) begin
        case (pass)
          P_MOD: begin
            env_y2_pre <= h_y1[band_idx][P_MOD];
            pass       <= P_ENV;
          end
          P_ENV: pass <= P_CAR;
          default: begin
            band_valid_out <= 1'b1;
            band_out       <= ROW_W'(band_idx);
            envelope_out   <= h_y0[band_idx][P_ENV];
            carrier_out    <= eng_y_n_in;
            pass           <= P_MOD;
            if (last_band) begin
              frame_done_out <= 1'b1;
              band_idx       <= '0;
              mod_x2         <= mod_x1;
              mod_x1         <= mod_x0;
              car_x2         <= car_x1;
              car_x1         <= car_x0;
            end else begin
              band_idx <= band_idx + BI_W'(1);
            end
          end
        endcase
      end
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)
      overrun_count_out <= '0;
    else if (valid_in && !ready_out && overrun_count_out != 16'hffff)
      overrun_count_out <= overrun_count_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_biquad_scheduler.sv
module tb_biquad_scheduler;
  localparam int NB = 2;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          valid_in = 1'b0;
  logic [31:0]   mod_in = '0, car_in = '0;
  logic          ready_out, eng_valid_out, band_valid_out, frame_done_out;
  logic [RW-1:0] eng_row_out, band_out;
  logic [31:0]   x_n, x_n1, x_n2, i_n1, i_n2, y_n1, y_n2;
  logic [31:0]   envelope_out, carrier_out;
  logic          eng_valid_in;
  logic [31:0]   eng_i_n_in, eng_y_n_in;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0]   ovr;
`endif

  // Engine model: latency 3, returns i = y = x_n (or y = -2^31 when neg_y).
  logic [2:0]  ev_pipe = '0;
  logic [31:0] xd0 = '0, xd1 = '0, xd2 = '0;
  logic        spur = 1'b0, neg_y = 1'b0, engine_off = 1'b0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    ev_pipe <= {ev_pipe[1:0], eng_valid_out & ~engine_off};
    xd0 <= x_n;
    xd1 <= xd0;
    xd2 <= xd1;
  end
  assign eng_valid_in = ev_pipe[2] | spur;
  assign eng_i_n_in   = xd2;
  assign eng_y_n_in   = neg_y ? 32'h8000_0000 : xd2;

  biquad_scheduler #(.N_BANDS(NB), .ROW_W(RW)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .valid_in            (valid_in),
    .modulator_sample_in (mod_in),
    .carrier_sample_in   (car_in),
    .ready_out           (ready_out),
    .eng_valid_out       (eng_valid_out),
    .eng_row_out         (eng_row_out),
    .eng_x_n_out         (x_n),
    .eng_x_n1_out        (x_n1),
    .eng_x_n2_out        (x_n2),
    .eng_i_n1_out        (i_n1),
    .eng_i_n2_out        (i_n2),
    .eng_y_n1_out        (y_n1),
    .eng_y_n2_out        (y_n2),
    .eng_valid_in        (eng_valid_in),
    .eng_i_n_in          (eng_i_n_in),
    .eng_y_n_in          (eng_y_n_in),
    .band_out            (band_out),
    .envelope_out        (envelope_out),
    .carrier_out         (carrier_out),
    .band_valid_out      (band_valid_out),
`ifdef SCHED_OVERRUN_CNT_EN
    .overrun_count_out   (ovr),
`endif
    .frame_done_out      (frame_done_out)
  );

  int n_cmp = 0, n_err = 0;
  int done_cyc, last_bv_cyc, hold_xn;
  logic [31:0] q_row[$], q_xn[$], q_xn1[$], q_xn2[$], q_yn1[$], q_in1[$];
  logic [31:0] q_env[$], q_car[$], q_band[$];
  int exp_rows[6] = '{0, 2, 0, 1, 2, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one frame from the accept cycle (cycle 0) until frame_done is seen.
  task automatic run_frame(input logic [31:0] m, input logic [31:0] c, input bit spam);
    int cyc;
    q_row.delete(); q_xn.delete(); q_xn1.delete(); q_xn2.delete();
    q_yn1.delete(); q_in1.delete(); q_env.delete(); q_car.delete(); q_band.delete();
    done_cyc = 0; last_bv_cyc = -1; hold_xn = -1;
    valid_in = 1'b1; mod_in = m; car_in = c;
    step();
    cyc = 1;
    if (!spam) valid_in = 1'b0;
    while (done_cyc == 0 && cyc < 60) begin
      if (eng_valid_out) begin
        q_row.push_back(32'(eng_row_out)); q_xn.push_back(x_n);
        q_xn1.push_back(x_n1); q_xn2.push_back(x_n2);
        q_yn1.push_back(y_n1); q_in1.push_back(i_n1);
      end
      if (cyc == 2) hold_xn = int'(x_n);
      if (band_valid_out) begin
        q_env.push_back(envelope_out); q_car.push_back(carrier_out);
        q_band.push_back(32'(band_out)); last_bv_cyc = cyc;
      end
      if (frame_done_out) done_cyc = cyc;
      step();
      cyc++;
    end
    valid_in = 1'b0;
    chk("frame_done_seen", 32'(done_cyc != 0), 32'd1);
    chk("issue_count", 32'(q_row.size()), 32'd6);
    chk("band_strobes", 32'(q_env.size()), 32'd2);
  endtask

  initial begin
    // Reset state
    repeat (5) step();
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_eng_valid", 32'(eng_valid_out), 32'd0);
    chk("rst_band_valid", 32'(band_valid_out), 32'd0);
    chk("rst_done", 32'(frame_done_out), 32'd0);
    chk("rst_row", 32'(eng_row_out), 32'd0);
    chk("rst_xn", x_n, 32'd0);
    chk("rst_env", envelope_out, 32'd0);
    rst_in = 1'b0;
    step();
    chk("ready_after_rst", 32'(ready_out), 32'd1);

    // Spurious engine strobe while idle
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_ready", 32'(ready_out), 32'd1);
    chk("spur_eng_valid", 32'(eng_valid_out), 32'd0);
    chk("spur_band_valid", 32'(band_valid_out), 32'd0);
    step();
    chk("spur_band_valid2", 32'(band_valid_out), 32'd0);

    // Frame 1: mod=5, car=7, zero history
    run_frame(32'd5, 32'd7, 1'b0);
    for (int k = 0; k < 6 && k < q_row.size(); k++)
      chk($sformatf("f1_row%0d", k), q_row[k], 32'(exp_rows[k]));
    if (q_xn.size() >= 2) begin
      chk("f1_mod0_xn", q_xn[0], 32'd5);
      chk("f1_mod0_xn1", q_xn1[0], 32'd0);
      chk("f1_env0_xn", q_xn[1], 32'd5);
    end
    chk("f1_hold_xn", 32'(hold_xn), 32'd5);
    if (q_env.size() == 2) begin
      chk("f1_b0_band", q_band[0], 32'd0);
      chk("f1_b0_env", q_env[0], 32'd5);
      chk("f1_b0_car", q_car[0], 32'd7);
      chk("f1_b1_band", q_band[1], 32'd1);
      chk("f1_b1_env", q_env[1], 32'd5);
      chk("f1_b1_car", q_car[1], 32'd7);
    end
    chk("f1_done_cycle", 32'(done_cyc), 32'd25);
    chk("f1_done_with_last_bv", 32'(last_bv_cyc), 32'(done_cyc));
    chk("f1_ready_after", 32'(ready_out), 32'd1);
    chk("f1_idle_after", 32'(eng_valid_out), 32'd0);

    // Frame 2: mod=9, car=11 -> history from frame 1
    run_frame(32'd9, 32'd11, 1'b0);
    if (q_xn.size() == 6) begin
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("f2_mod%0d_xn", b), q_xn[3*b], 32'd9);
        chk($sformatf("f2_mod%0d_xn1", b), q_xn1[3*b], 32'd5);
        chk($sformatf("f2_mod%0d_xn2", b), q_xn2[3*b], 32'd0);
        chk($sformatf("f2_mod%0d_yn1", b), q_yn1[3*b], 32'd5);
      end
      chk("f2_env0_xn", q_xn[1], 32'd9);
      chk("f2_env0_xn1", q_xn1[1], 32'd5);
      chk("f2_env0_xn2", q_xn2[1], 32'd0);
      chk("f2_env0_yn1", q_yn1[1], 32'd5);
      chk("f2_car0_xn", q_xn[2], 32'd11);
      chk("f2_car0_xn1", q_xn1[2], 32'd7);
      chk("f2_car0_in1", q_in1[2], 32'd7);
    end
    chk("f2_done_cycle", 32'(done_cyc), 32'd25);

    // Frame 3: engine returns y=-2^31 -> ENV magnitude saturates
    neg_y = 1'b1;
    run_frame(32'd3, 32'd4, 1'b0);
    neg_y = 1'b0;
    if (q_xn.size() == 6) begin
      chk("f3_env0_xn_sat", q_xn[1], 32'h7fff_ffff);
      chk("f3_env0_xn1", q_xn1[1], 32'd9);
      chk("f3_env0_xn2", q_xn2[1], 32'd5);
      chk("f3_mod1_xn2", q_xn2[3], 32'd5);
    end

    // Frame 4: valid_in held high every cycle -> only one frame runs
    run_frame(32'd1, 32'd2, 1'b1);
    chk("spam_done_cycle", 32'(done_cyc), 32'd25);
    chk("spam_ready_after", 32'(ready_out), 32'd1);
    chk("spam_no_restart", 32'(eng_valid_out), 32'd0);
`ifdef SCHED_OVERRUN_CNT_EN
    chk("overrun_25", 32'(ovr), 32'd25);
`endif

    // Reset during the WAIT of ENV(1)
    valid_in = 1'b1; mod_in = 32'd4; car_in = 32'd6;
    step();
    valid_in = 1'b0;
    begin
      int seen = 0, guard = 0;
      while (seen < 5 && guard < 40) begin
        if (eng_valid_out) seen++;
        if (seen < 5) step();
        guard++;
      end
      chk("reach_env1", 32'(eng_row_out), 32'd2);
    end
    step();
    rst_in = 1'b1;
    step();
    chk("mid_rst_band_valid", 32'(band_valid_out), 32'd0);
    chk("mid_rst_ready", 32'(ready_out), 32'd0);
    chk("mid_rst_xn", x_n, 32'd0);
    chk("mid_rst_env", envelope_out, 32'd0);
    step();
    chk("mid_rst_band_valid2", 32'(band_valid_out), 32'd0);
    rst_in = 1'b0;
    step();
    chk("post_rst_ready", 32'(ready_out), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("post_rst_quiet%0d", k), 32'(band_valid_out | eng_valid_out | frame_done_out), 32'd0);
      step();
    end
    run_frame(32'd9, 32'd8, 1'b0);
    if (q_xn.size() == 6) begin
      chk("z_mod0_xn", q_xn[0], 32'd9);
      chk("z_mod0_xn1", q_xn1[0], 32'd0);
      chk("z_mod0_xn2", q_xn2[0], 32'd0);
      chk("z_mod0_yn1", q_yn1[0], 32'd0);
      chk("z_mod0_in1", q_in1[0], 32'd0);
      chk("z_env0_xn1", q_xn1[1], 32'd0);
      chk("z_car0_xn1", q_xn1[2], 32'd0);
    end

`ifdef SCHED_OVERRUN_CNT_EN
    chk("overrun_cleared", 32'(ovr), 32'd0);
    // Stall the engine so the scheduler stays busy, then flood valid_in.
    engine_off = 1'b1;
    valid_in = 1'b1; mod_in = 32'd1; car_in = 32'd1;
    repeat (70001) @(posedge clk_in);
    #1;
    chk("overrun_sat", 32'(ovr), 32'd65535);
    valid_in = 1'b0;
    rst_in = 1'b1;
    step();
    chk("overrun_rst", 32'(ovr), 32'd0);
    rst_in = 1'b0;
    engine_off = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
